// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with NRD combinational read ports,
// a valid/ready write-back port and a per-register pending-write scoreboard.
//   clk, rst (async, active-low)
//   issue_valid/issue_ready/issue_rd : reserve a destination register
//   rs_addr/rs_data/rs_busy          : NRD read ports with pending-write flag
//   wb_valid/wb_ready/wb_addr/wb_data: write-back port
//   commit_valid/commit_addr/commit_data : registered pulse per accepted write
//   wb_err                           : sticky, write-back with no reservation
// Optional macro REGFILE_BYPASS_EN forwards the write-back value to read ports.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int CNT_W = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [AW-1:0]        issue_rd,
  input  logic [NRD*AW-1:0]    rs_addr,
  output logic [NRD*WIDTH-1:0] rs_data,
  output logic [NRD-1:0]       rs_busy,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [AW-1:0]        wb_addr,
  input  logic [WIDTH-1:0]     wb_data,
  output logic                 commit_valid,
  output logic [AW-1:0]        commit_addr,
  output logic [WIDTH-1:0]     commit_data,
  output logic                 wb_err
);
  logic [CNT_W-1:0] cnt [NREG];
  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  inc, dec;
  logic             issue_fire, wb_fire, byp;
  logic [AW-1:0]    a;

  assign wb_ready    = rst;
  // x0 never reserves, so it never saturates
  assign issue_ready = rst && (issue_rd == '0 || cnt[issue_rd] != '1);
  assign issue_fire  = issue_valid && issue_ready;
  assign wb_fire     = wb_valid && wb_ready;

  // underflow is blocked by requiring a nonzero count before decrementing
  always_comb begin
    inc = '0;
    dec = '0;
    inc[issue_rd] = issue_fire && issue_rd != '0;
    dec[wb_addr]  = wb_fire && wb_addr != '0 && cnt[wb_addr] != '0;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r]  <= '0;
        regs[r] <= '0;
      end
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      commit_data  <= '0;
      wb_err       <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt[r] + CNT_W'(inc[r]) - CNT_W'(dec[r]);
      if (wb_fire && wb_addr != '0)
        regs[wb_addr] <= wb_data;
      commit_valid <= wb_fire;
      if (wb_fire) begin
        commit_addr <= wb_addr;
        commit_data <= wb_data;
      end
      wb_err <= wb_err | (wb_fire && wb_addr != '0 && cnt[wb_addr] == '0);
    end

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    a       = '0;
    byp     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      byp = wb_fire && wb_addr == a && a != '0;
`else
      byp = 1'b0;
`endif
      rs_data[i*WIDTH +: WIDTH] = byp ? wb_data : (a == '0 ? '0 : regs[a]);
      // a bypassed write that retires the last reservation clears busy early
      rs_busy[i] = cnt[a] != '0 && !(byp && cnt[a] == CNT_W'(1));
    end
  end
endmodule
